// File: rtl/param_memory_pkg.sv
// Shared types and constants for param_memory: controller states, default sizes
// and the boot program copied into memory after reset.
package param_memory_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_BOOT_LEN = 26;
    localparam int BOOT_IMG_LEN = 26;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_IDLE  = 2'd2
    } state_e;

    localparam logic [31:0] BOOT_IMG [BOOT_IMG_LEN] = '{
        32'h00000093, 32'h00000113, 32'h00000193, 32'h00000213,
        32'h00000293, 32'h00000313, 32'h00000393, 32'h00000413,
        32'h10000537, 32'h00050513, 32'h00100593, 32'h00b52023,
        32'h00158593, 32'h00452603, 32'hfe061ee3, 32'h00c52223,
        32'h00000697, 32'h01868693, 32'h0006a703, 32'h00e52423,
        32'h0040006f, 32'hdeadc0de, 32'h0badf00d, 32'h12345678,
        32'hcafebabe, 32'h8badf00d
    };

endpackage

// File: rtl/param_memory_boot_rom.sv
// Combinational boot word lookup; indices past the stored image read as zero.
module boot_rom
    import param_memory_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] idx_i,
    output logic [DATA_W-1:0] word_o
);

    always_comb begin
        word_o = '0;
        // Compare as int so narrow indices never alias into the image.
        for (int i = 0; i < BOOT_IMG_LEN; i++) begin
            if (int'(idx_i) == i) word_o = DATA_W'(BOOT_IMG[i]);
        end
    end

endmodule

// File: rtl/param_memory.sv
// Byte-writable single-port memory that clears itself and, when
// PARAM_MEMORY_BOOT_IMAGE_EN is defined, loads a boot image before serving requests.
module param_memory
    import param_memory_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int BOOT_LEN = DEF_BOOT_LEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  rw,
    input  logic [ADDR_W-1:0]     add,
    input  logic [DATA_W-1:0]     wData,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     rData,
    output logic                  rValid,
    output logic                  busy
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q;
    logic                rvalid_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [NB-1:0]       mem_be;
    logic                rd_acc;

`ifdef PARAM_MEMORY_BOOT_IMAGE_EN
    localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(BOOT_LEN-1);
    logic [DATA_W-1:0] boot_word;

    boot_rom #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_boot_rom (
        .idx_i  (cnt_q),
        .word_o (boot_word)
    );
`else
    localparam int unused_boot_len = BOOT_LEN;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    cnt_d = '0;
`ifdef PARAM_MEMORY_BOOT_IMAGE_EN
                    // An empty image skips LOAD so init stays exactly DEPTH cycles.
                    state_d = (BOOT_LEN == 0) ? ST_IDLE : ST_LOAD;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_LOAD: begin
`ifdef PARAM_MEMORY_BOOT_IMAGE_EN
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LOAD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        rd_acc    = (state_q == ST_IDLE) && enable && !rw;
        mem_we    = 1'b0;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        mem_be    = '1;
        case (state_q)
            ST_CLEAR: mem_we = 1'b1;
            ST_LOAD: begin
`ifdef PARAM_MEMORY_BOOT_IMAGE_EN
                mem_we    = 1'b1;
                mem_wdata = boot_word;
`endif
            end
            ST_IDLE: begin
                mem_we    = enable && rw;
                mem_addr  = add;
                mem_wdata = wData;
                mem_be    = be;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) rdata_q <= mem[add];
        end
    end

    assign rData  = rdata_q;
    assign rValid = rvalid_q;

endmodule

// File: tb/tb_param_memory.sv
// Randomized scoreboard bench for param_memory against an array reference model.
module tb_param_memory;
    import param_memory_pkg::*;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam int BL    = 26;
`ifdef PARAM_MEMORY_BOOT_IMAGE_EN
    localparam int INIT   = DEPTH + BL;
    localparam int INIT_S = 16 + 4;
`else
    localparam int INIT   = DEPTH;
    localparam int INIT_S = 16;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          enable, rw;
    logic [AW-1:0] add;
    logic [31:0]   wData;
    logic [3:0]    be;
    logic [31:0]   rData;
    logic          rValid, busy;
    logic [31:0]   s_rData;
    logic          s_rValid, s_busy;

    always #5 clk = ~clk;

    param_memory dut (
        .clk(clk), .reset(reset), .enable(enable), .rw(rw), .add(add),
        .wData(wData), .be(be), .rData(rData), .rValid(rValid), .busy(busy)
    );

    param_memory #(.ADDR_W(4), .BOOT_LEN(4)) u_small (
        .clk(clk), .reset(reset), .enable(1'b0), .rw(1'b0), .add(4'd0),
        .wData(32'd0), .be(4'd0), .rData(s_rData), .rValid(s_rValid), .busy(s_busy)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_q [$];
    bit          mon_en = 0;
    bit          model_idle = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory image right after initialisation: all zero, boot program on top.
    function automatic void ref_init();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`ifdef PARAM_MEMORY_BOOT_IMAGE_EN
        for (int i = 0; i < BL; i++) ref_mem[i] = BOOT_IMG[i];
`endif
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (rValid === 1'b1) begin
                if (exp_q.size() == 0) check("spurious_rvalid", 32'd1, 32'd0);
                else check("rdata", rData, exp_q.pop_front());
            end else if (exp_q.size() != 0) begin
                check("missing_rvalid", {31'd0, rValid}, 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; request is taken at the next edge, then model updates.
    task automatic op(input bit en, input bit wr, input int a, input logic [31:0] d,
                      input logic [3:0] b);
        logic [31:0] mask;
        enable = en; rw = wr; add = AW'(a); wData = d; be = b;
        @(posedge clk); #1;
        if (en && model_idle) begin
            if (wr) begin
                mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
                ref_mem[a] = (ref_mem[a] & ~mask) | (d & mask);
            end else begin
                exp_q.push_back(ref_mem[a]);
            end
        end
    endtask

    // Reset, release, and measure busy; a write to address 3 is held on enable
    // through the whole busy window and must be ignored.
    task automatic init_seq();
        int n;
        mon_en = 0; model_idle = 0; exp_q.delete();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b1; rw = 1'b1; add = AW'(3); wData = 32'h12345678; be = 4'hf;
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        enable = 1'b0;
        check("busy_len", 32'(n), 32'(INIT));
        ref_init();
        model_idle = 1; mon_en = 1;
    endtask

    task automatic small_count();
        int n;
        @(posedge reset);
        n = 0;
        while (s_busy === 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("small_busy_len", 32'(n), 32'(INIT_S));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; enable = 1'b0; rw = 1'b0; add = '0; wData = '0; be = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", rData, 32'd0);
        check("rst_rvalid", {31'd0, rValid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);

        fork
            init_seq();
            small_count();
        join

        // Boot region back-to-back plus first word beyond it.
        for (int i = 0; i <= BL; i++) op(1, 0, i, '0, '0);
        op(0, 0, 0, '0, '0);

        op(1, 1, 5, 32'hDEADBEEF, 4'b0101);
        op(1, 0, 5, '0, '0);
        op(1, 1, 100, 32'hDEADBEEF, 4'b0101);
        op(1, 0, 100, '0, '0);
        op(1, 1, 7, 32'hFFFFFFFF, 4'b0000);
        op(1, 0, 7, '0, '0);
        op(1, 1, DEPTH-1, 32'hA5A55A5A, 4'b1111);
        op(1, 0, DEPTH-1, '0, '0);
        op(0, 0, 0, '0, '0);

        for (int k = 0; k < 400; k++) begin
            op($urandom_range(0, 3) != 0, $urandom_range(0, 1),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH-1))
                                           : int'($urandom_range(0, 31)),
               $urandom, 4'($urandom_range(0, 15)));
        end
        op(0, 0, 0, '0, '0);
        op(0, 0, 0, '0, '0);

        // Async reset while a read result is being presented.
        op(1, 0, 1, '0, '0);
        mon_en = 0; exp_q.delete();
        reset = 1'b0;
        #1;
        check("async_rdata", rData, 32'd0);
        check("async_rvalid", {31'd0, rValid}, 32'd0);
        check("async_busy", {31'd0, busy}, 32'd1);

        // Abandon CLEAR partway through.
        @(negedge clk);
        reset = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        check("mid_clear_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_clear_rdata", rData, 32'd0);
        check("mid_clear_rvalid", {31'd0, rValid}, 32'd0);

        init_seq();
        op(1, 0, 3, '0, '0);
        op(1, 0, 0, '0, '0);
        op(1, 0, 1, '0, '0);
        op(1, 0, 2, '0, '0);
        op(1, 0, BL, '0, '0);
        op(0, 0, 0, '0, '0);
        op(0, 0, 0, '0, '0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
